// File: rtl/tensor_stream_builder_pkg.sv
// Shared constants, state encoding and index type for the tensor stream builder.
package tensor_pkg;

    localparam int TENSOR_WIDTH    = 17;
    localparam int TENSOR_ROWS     = 8;
    localparam int TENSOR_COLS     = 8;
    localparam int TENSOR_CHANNELS = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic [$clog2(TENSOR_ROWS)-1:0]     row;
        logic [$clog2(TENSOR_COLS)-1:0]     col;
        logic [$clog2(TENSOR_CHANNELS)-1:0] cha;
    } tensor_idx_t;

    // Counter width that never collapses to zero bits for a dimension of size 1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tensor_stream_builder_counter.sv
// Raster index generator: channel fastest, then column, then row, with sync clear
// and a flag marking the final index of a frame.
module tensor_raster_counter
    import tensor_pkg::*;
#(
    parameter int ROWS     = TENSOR_ROWS,
    parameter int COLS     = TENSOR_COLS,
    parameter int CHANNELS = TENSOR_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    output logic [cnt_w(ROWS)-1:0]     row,
    output logic [cnt_w(COLS)-1:0]     col,
    output logic [cnt_w(CHANNELS)-1:0] cha,
    output logic                      at_last
);
    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);
    localparam int HW = cnt_w(CHANNELS);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [HW-1:0] cha_q, cha_d;

    assign row     = row_q;
    assign col     = col_q;
    assign cha     = cha_q;
    assign at_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1)) &&
                     (cha_q == HW'(CHANNELS - 1));

    // Clear wins over enable so an aborted frame restarts at (0,0,0).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cha_d = cha_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
            cha_d = '0;
        end else if (en) begin
            if (cha_q == HW'(CHANNELS - 1)) begin
                cha_d = '0;
                if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(ROWS - 1)) row_d = '0;
                    else                        row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end else begin
                cha_d = cha_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            cha_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cha_q <= cha_d;
        end
    end

endmodule

// File: rtl/tensor_stream_builder.sv
// Assembles a raster element stream into a ROWS x COLS x CHANNELS tensor with a valid/ack hand-off.
// Define TENSOR_BUILDER_DBUF_EN for a ping-pong pair of banks instead of a single bank.
module tensor_stream_builder
    import tensor_pkg::*;
#(
    parameter int WIDTH    = TENSOR_WIDTH,
    parameter int ROWS     = TENSOR_ROWS,
    parameter int COLS     = TENSOR_COLS,
    parameter int CHANNELS = TENSOR_CHANNELS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic signed [WIDTH-1:0]             s_data,
    input  logic                                s_last,
    output logic [ROWS*COLS*CHANNELS*WIDTH-1:0] tensor,
    output logic                                t_valid,
    input  logic                                t_ack,
    output logic                                frame_err
);
    localparam int ELEMS = ROWS * COLS * CHANNELS;
    localparam int RW    = cnt_w(ROWS);
    localparam int CW    = cnt_w(COLS);
    localparam int HW    = cnt_w(CHANNELS);
    localparam int IW    = cnt_w(ELEMS);
`ifdef TENSOR_BUILDER_DBUF_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif

    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic [HW-1:0]    cha;
    logic             at_last;
    logic             accept;
    logic             clr_cnt;
    logic [IW-1:0]    wr_idx;
    logic             fill_sel;
    logic             show_sel;
    state_e           bank_state_q [BANKS];
    state_e           bank_state_d [BANKS];
    logic [WIDTH-1:0] mem_q [BANKS][ELEMS];
    logic [WIDTH-1:0] mem_d [BANKS][ELEMS];
    logic             frame_err_q, frame_err_d;

    tensor_raster_counter #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .CHANNELS (CHANNELS)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (accept),
        .clr     (clr_cnt),
        .row     (row),
        .col     (col),
        .cha     (cha),
        .at_last (at_last)
    );

`ifdef TENSOR_BUILDER_DBUF_EN
    // Fill and show pointers each alternate independently, so the shown bank is always the older frame.
    logic fill_bank_q, fill_bank_d;
    logic show_bank_q, show_bank_d;
    assign fill_sel = fill_bank_q;
    assign show_sel = show_bank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank_q <= 1'b0;
            show_bank_q <= 1'b0;
        end else begin
            fill_bank_q <= fill_bank_d;
            show_bank_q <= show_bank_d;
        end
    end
`else
    assign fill_sel = 1'b0;
    assign show_sel = 1'b0;
`endif

    assign s_ready   = (bank_state_q[fill_sel] == FILL);
    assign t_valid   = (bank_state_q[show_sel] == HOLD);
    assign accept    = s_valid && s_ready;
    assign frame_err = frame_err_q;
    assign wr_idx    = IW'((int'(row) * COLS + int'(col)) * CHANNELS + int'(cha));

    always_comb begin
        tensor = '0;
        for (int i = 0; i < ELEMS; i++) begin
            tensor[i*WIDTH +: WIDTH] = mem_q[show_sel][IW'(i)];
        end
    end

    always_comb begin
        bank_state_d = bank_state_q;
        mem_d        = mem_q;
        frame_err_d  = frame_err_q;
        clr_cnt      = 1'b0;
`ifdef TENSOR_BUILDER_DBUF_EN
        fill_bank_d  = fill_bank_q;
        show_bank_d  = show_bank_q;
`endif
        if (t_valid && t_ack) begin
            bank_state_d[show_sel] = FILL;
`ifdef TENSOR_BUILDER_DBUF_EN
            show_bank_d = ~show_bank_q;
`endif
        end
        // A completing beat and an ack never target the same bank, so both updates can coexist.
        if (accept) begin
            mem_d[fill_sel][wr_idx] = s_data;
            if (at_last) begin
                bank_state_d[fill_sel] = HOLD;
                if (!s_last) frame_err_d = 1'b1;
`ifdef TENSOR_BUILDER_DBUF_EN
                fill_bank_d = ~fill_bank_q;
`endif
            end else if (s_last) begin
                frame_err_d = 1'b1;
                clr_cnt     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state_q <= '{default: FILL};
            mem_q        <= '{default: '{default: '0}};
            frame_err_q  <= 1'b0;
        end else begin
            bank_state_q <= bank_state_d;
            mem_q        <= mem_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_tensor_stream_builder.sv
// Randomised self-checking bench for tensor_stream_builder against a frame-level reference model.
// Adds a ping-pong scenario when TENSOR_BUILDER_DBUF_EN is defined.
module tb_tensor_stream_builder;

    localparam int W  = 17;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int CH = 3;
    localparam int N  = R * C * CH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic [N*W-1:0]      tensor;
    logic                t_valid;
    logic                t_ack = 1'b0;
    logic                frame_err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model_frame [N];
    logic [W-1:0] model_done  [N];
    int           model_pos;
    bit           model_err;

    tensor_stream_builder #(
        .WIDTH    (W),
        .ROWS     (R),
        .COLS     (C),
        .CHANNELS (CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .tensor    (tensor),
        .t_valid   (t_valid),
        .t_ack     (t_ack),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: beat k of a frame lands at flat index k = (r*C+c)*CH+ch.
    function automatic void model_reset();
        model_pos = 0;
        model_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            model_frame[i] = '0;
            model_done[i]  = '0;
        end
    endfunction

    function automatic void model_beat(input logic [W-1:0] d, input logic last);
        model_frame[model_pos] = d;
        model_pos++;
        if (model_pos == N) begin
            if (!last) model_err = 1'b1;
            model_done = model_frame;
            model_pos  = 0;
        end else if (last) begin
            model_err = 1'b1;
            model_pos = 0;
        end
    endfunction

    function automatic logic [W-1:0] elem(input int r, input int c, input int h);
        return tensor[((r * C + c) * CH + h) * W +: W];
    endfunction

    function automatic int count_bad(input logic [W-1:0] exp_t [N], output int first,
                                     output logic [W-1:0] got, output logic [W-1:0] want);
        int bad = 0;
        first = -1;
        got   = '0;
        want  = '0;
        for (int i = 0; i < N; i++) begin
            if (tensor[i*W +: W] !== exp_t[i]) begin
                if (bad == 0) begin
                    first = i;
                    got   = tensor[i*W +: W];
                    want  = exp_t[i];
                end
                bad++;
            end
        end
        return bad;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic drive_beat(input logic [W-1:0] d, input logic last, input int gap, output int waited);
        waited = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("[TB] FAIL beat_accept: s_ready=%0b after %0d cycles, required 1", s_ready, waited);
        end else begin
            model_beat(d, last);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        t_ack   = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_ack();
        t_ack = 1'b1;
        @(posedge clk);
        #1;
        t_ack = 1'b0;
    endtask

    task automatic test_reset();
        int bad, first;
        logic [W-1:0] got, want;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (t_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_t_valid: got %0b required 0", t_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_frame_err: got %0b required 0", frame_err);
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL reset_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_s_ready: got %0b required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int bad, first, w;
        logic [W-1:0] got, want;
        logic [N*W-1:0] snap;
        for (int k = 0; k < N; k++) begin
            drive_beat(W'(k), k == N - 1, 0, w);
            if (k == N - 2) begin
                checks++;
                if (t_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_early_valid: got %0b required 0", t_valid);
                end
            end
        end
        checks++;
        if (t_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_t_valid: got %0b required 1", t_valid);
        end
        checks++;
        if (elem(2, 5, 1) !== W'(64)) begin
            errors++;
            $display("[TB] FAIL full_elem_2_5_1: got %0d required 64", elem(2, 5, 1));
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL full_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
`ifndef TENSOR_BUILDER_DBUF_EN
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_s_ready: got %0b required 0", s_ready);
        end
        snap = tensor;
        s_valid = 1'b1;
        s_last  = 1'b1;
        repeat (3) begin
            s_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (tensor !== snap || t_valid !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_stable: t_valid=%0b frame_err=%0b changed=%0b, required 1 0 0",
                     t_valid, frame_err, tensor !== snap);
        end
`endif
        do_ack();
        checks++;
        if (t_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_ack: t_valid=%0b s_ready=%0b required 0 1", t_valid, s_ready);
        end
    endtask

    task automatic test_gaps();
        int bad, first, w;
        logic [W-1:0] got, want;
        for (int k = 0; k < N; k++) begin
            t_ack = (k == N - 1) ? 1'b0 : 1'($urandom % 2);
            drive_beat(W'(k), k == N - 1, ($urandom % 2) ? int'($urandom_range(1, 2)) : 0, w);
        end
        t_ack = 1'b0;
        checks++;
        if (t_valid !== 1'b1 || frame_err !== model_err) begin
            errors++;
            $display("[TB] FAIL gaps_flags: t_valid=%0b frame_err=%0b required 1 %0b", t_valid, frame_err, model_err);
        end
        checks++;
        if (elem(2, 5, 1) !== W'(64)) begin
            errors++;
            $display("[TB] FAIL gaps_elem_2_5_1: got %0d required 64", elem(2, 5, 1));
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL gaps_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
        do_ack();
    endtask

    task automatic test_early_last();
        int bad, first, w;
        logic [W-1:0] got, want;
        for (int k = 0; k < 100; k++) drive_beat(W'($urandom), k == 99, 0, w);
        checks++;
        if (frame_err !== 1'b1 || t_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_flags: frame_err=%0b t_valid=%0b required 1 0", frame_err, t_valid);
        end
        for (int k = 0; k < N; k++) begin
            drive_beat(W'($urandom), k == N - 1, $urandom % 2, w);
            if (k == N - 2) begin
                checks++;
                if (t_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL early_restart: t_valid=%0b before final beat, required 0", t_valid);
                end
            end
        end
        checks++;
        if (t_valid !== 1'b1 || frame_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_done: t_valid=%0b frame_err=%0b required 1 1", t_valid, frame_err);
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL early_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
        do_ack();
    endtask

    task automatic test_no_last();
        int bad, first, w;
        logic [W-1:0] got, want;
        do_reset();
        for (int k = 0; k < N; k++) drive_beat(W'($urandom), 1'b0, 0, w);
        checks++;
        if (t_valid !== 1'b1 || frame_err !== model_err) begin
            errors++;
            $display("[TB] FAIL nolast_flags: t_valid=%0b frame_err=%0b required 1 %0b", t_valid, frame_err, model_err);
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL nolast_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int bad, first, w;
        logic [W-1:0] got, want;
        do_reset();
        for (int k = 0; k < 150; k++) drive_beat(W'($urandom), 1'b0, 0, w);
        rst_n = 1'b0;
        model_reset();
        #1;
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0 || t_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: %0d bad elems t_valid=%0b frame_err=%0b required 0 0 0", bad, t_valid, frame_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) drive_beat(W'(-k), k == N - 1, 0, w);
        checks++;
        if (elem(0, 0, 0) !== W'(0) || elem(7, 7, 2) !== W'(-191)) begin
            errors++;
            $display("[TB] FAIL midreset_corners: got %0h %0h required 0 %0h", elem(0, 0, 0), elem(7, 7, 2), W'(-191));
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0 || t_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_tensor: %0d bad, first idx %0d got %0h required %0h t_valid=%0b", bad, first, got, want, t_valid);
        end
        do_ack();
    endtask

`ifdef TENSOR_BUILDER_DBUF_EN
    task automatic test_dbuf();
        int bad, first, w, stalls;
        logic [W-1:0] got, want;
        logic [W-1:0] frame_a [N];
        do_reset();
        for (int k = 0; k < N; k++) drive_beat(W'($urandom), k == N - 1, 0, w);
        frame_a = model_done;
        checks++;
        if (t_valid !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbuf_a_hold: t_valid=%0b s_ready=%0b required 1 1", t_valid, s_ready);
        end
        stalls = 0;
        for (int k = 0; k < N - 1; k++) begin
            drive_beat(W'($urandom), 1'b0, 0, w);
            stalls += w;
        end
        bad = count_bad(frame_a, first, got, want);
        checks++;
        if (bad !== 0 || stalls !== 0) begin
            errors++;
            $display("[TB] FAIL dbuf_a_stable: %0d bad elems, %0d stall cycles, required 0 0", bad, stalls);
        end
        t_ack = 1'b1;
        drive_beat(W'($urandom), 1'b1, 0, w);
        t_ack = 1'b0;
        checks++;
        if (t_valid !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbuf_swap_flags: t_valid=%0b s_ready=%0b required 1 1", t_valid, s_ready);
        end
        bad = count_bad(model_done, first, got, want);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL dbuf_b_tensor: %0d bad, first idx %0d got %0h required %0h", bad, first, got, want);
        end
        do_ack();
        checks++;
        if (t_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbuf_b_ack: t_valid=%0b required 0", t_valid);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting tensor_stream_builder bench");
        test_reset();
        test_full_frame();
        test_gaps();
        test_early_last();
        test_no_last();
        test_reset_mid();
`ifdef TENSOR_BUILDER_DBUF_EN
        test_dbuf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
